debouncer_multi: RTL and testbench
==================================

Name: debouncer_multi

Overview:
Parametrised multi-channel successor to the single-channel debouncer.
- Each channel of `data_in`:
  - is synchronised with two flops;
  - is filtered so `data_out` changes only after the synchronised level has differed from it for `STABLE_CYCLES` consecutive qualified ticks;
  - produces one-cycle rise/fall pulses.
- Sits between board pins (buttons, switches) and FSM logic such as the pattern checker.
- The shared `tick` input allows a common prescaler, so long debounce windows need no wide per-channel counters.

Parameters:
- `NUM_CH`, 4: number of independent channels, ≥1.
- `STABLE_CYCLES`, 1000000: required consecutive mismatching ticks before `data_out` follows, ≥2.
- `RST_VAL`, 1'b0: reset level of sync flops and `data_out`, common to all channels.
- `LONG_CYCLES`, 50000000: ticks `data_out` must stay 1 before `long_press` fires. Used only with `DEBOUNCE_LONG_PRESS_EN`; must be > `STABLE_CYCLES`.

Ports:
- `clk`, input, 1: single clock; all flops on rising edge.
- `rst_n`, input, 1: asynchronous active-low reset; assertion is asynchronous, deassertion is synchronised externally.
- `tick`, input, 1: counter qualifier; tie to 1 for per-clock counting.
- `data_in`, input, `NUM_CH`: raw asynchronous inputs.
- `data_out`, output, `NUM_CH`: debounced levels, registered.
- `rise`, output, `NUM_CH`: one-cycle pulse when `data_out[i]` goes 0→1, registered.
- `fall`, output, `NUM_CH`: one-cycle pulse when `data_out[i]` goes 1→0, registered.
- `long_press`, output, `NUM_CH`: one-cycle long-hold pulse; constant 0 without the macro.

Behaviour:
- Reset (`rst_n`=0, asynchronous):
  - sync flops and `data_out` = {`NUM_CH`{`RST_VAL`}};
  - counters = 0;
  - `rise`, `fall` and `long_press` = 0.
- Synchroniser: `s1[i]` <= `data_in[i]`; `s2[i]` <= `s1[i]`. Only `s2` is used downstream.
- Per-channel counter `cnt[i]`, width max(1, $clog2(`STABLE_CYCLES`)). Each edge, first matching rule wins:
  - `s2[i]` == `data_out[i]`: `cnt[i]` <= 0, independent of `tick`.
  - `tick`=1 and `cnt[i]` == `STABLE_CYCLES`-1: `data_out[i]` <= `s2[i]`; `cnt[i]` <= 0; `rise[i]` <= `s2[i]`; `fall[i]` <= ~`s2[i]`.
  - `tick`=1: `cnt[i]` <= `cnt[i]`+1.
  - Otherwise `cnt[i]` holds.
- Pulse clearing: `rise`/`fall` are 0 on every edge where no update occurs, so each pulse lasts exactly one cycle.
- Latency with `tick`=1: a clean change on `data_in[i]` reaches `data_out[i]` on the (`STABLE_CYCLES`+2)th rising edge, counting the first capturing edge as 1.
  - The pulse asserts on the same edge as the `data_out` change.
- Glitch rejection: an `s2` excursion lasting fewer than `STABLE_CYCLES` ticks leaves `data_out` unchanged; the counter returns to 0 as soon as `s2` matches again.
- Counter bounds: the counter never exceeds `STABLE_CYCLES`-1 and never wraps.
- Channel independence: channels are fully independent; simultaneous updates on several channels are allowed.
- Reset mid-count: counters clear, and `data_out` returns to `RST_VAL` with no pulse. After release, a held input re-qualifies from 0.

Optional Feature:
`DEBOUNCE_LONG_PRESS_EN`
- Defined:
  - per-channel `hold[i]` counter, width $clog2(`LONG_CYCLES`+1), plus a `fired[i]` flag;
  - while `data_out[i]`=1 and `tick`=1, `hold[i]` increments;
  - when `hold[i]` reaches `LONG_CYCLES`-1 on a tick with `fired[i]`=0: `long_press[i]` pulses for one cycle and `fired[i]` <= 1;
  - the counter saturates, so `long_press` fires at most once per press;
  - `data_out[i]`=0 clears `hold[i]` and `fired[i]`;
  - reset clears both.
- Undefined: no hold logic is generated and `long_press` = 0.

Test Plan:
Test parameters: `NUM_CH`=4, `STABLE_CYCLES`=8, `RST_VAL`=0, `tick`=1, `LONG_CYCLES`=20.
- Reset/qualify: `rst_n`=0 with `data_in`=4'hF → all outputs 0. Release and hold 4'hF → `data_out`=4'hF on edge 10 after release; `rise`=4'hF for exactly one cycle; `fall`=0.
- Glitch width: `data_in[0]` high for 7 cycles then low → `data_out[0]` stays 0, no pulse. High for 8 cycles → `data_out[0]`=1 for one update, `rise[0]` pulses, then `fall[0]` follows 8 ticks after `s2` falls.
- Bounce: ch1 toggles every 3 cycles for 30 cycles, then settles high → no pulses during bouncing; `rise[1]` occurs exactly 10 edges after the last `data_in` change; channels 0, 2 and 3 are unaffected.
- Tick gating: `tick` asserted every 4th cycle and `data_in[2]` steps 0→1 → update after the 8th qualifying tick. `cnt` holds on non-tick cycles; `s2` matching mid-count clears `cnt` even without `tick`.
- Reset mid-count: `data_in[3]`=1, `rst_n` pulsed low after 5 ticks → outputs drop to 0 immediately (asynchronously), no `fall` pulse. After release, `rise[3]` occurs 10 edges later.
- Long press (macro defined): hold ch0 high → `rise[0]`, then `long_press[0]` pulses once 20 ticks after `data_out[0]`=1 and not again while held. Release and re-press repeats the sequence. With the macro undefined, `long_press` stays 0.

Source files
------------

// File: rtl/debouncer_multi.sv
// debouncer_multi: per-channel two-flop synchroniser, tick-qualified debounce filter and rise/fall pulses.
// Define DEBOUNCE_LONG_PRESS_EN to add a one-shot long-hold pulse per channel.
module debouncer_multi #(
  parameter int   NUM_CH        = 4,
  parameter int   STABLE_CYCLES = 1000000,
  parameter logic RST_VAL       = 1'b0,
  parameter int   LONG_CYCLES   = 50000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic [NUM_CH-1:0] data_in,
  output logic [NUM_CH-1:0] data_out,
  output logic [NUM_CH-1:0] rise,
  output logic [NUM_CH-1:0] fall,
  output logic [NUM_CH-1:0] long_press
);

  localparam int CW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  if (NUM_CH < 1 || STABLE_CYCLES < 2 || LONG_CYCLES <= STABLE_CYCLES) begin : g_param_check
    $error("debouncer_multi: invalid parameter combination");
  end

  logic [NUM_CH-1:0] s1;
  logic [NUM_CH-1:0] s2;
  logic [CW-1:0]     cnt [NUM_CH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= {NUM_CH{RST_VAL}};
      s2 <= {NUM_CH{RST_VAL}};
    end else begin
      s1 <= data_in;
      s2 <= s1;
    end
  end

  // A match with the current output clears the count regardless of tick, so any
  // glitch shorter than the window restarts qualification from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out <= {NUM_CH{RST_VAL}};
      rise     <= '0;
      fall     <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        rise[i] <= 1'b0;
        fall[i] <= 1'b0;
        if (s2[i] == data_out[i]) begin
          cnt[i] <= '0;
        end else if (tick && (cnt[i] == CNT_LAST)) begin
          data_out[i] <= s2[i];
          cnt[i]      <= '0;
          rise[i]     <= s2[i];
          fall[i]     <= ~s2[i];
        end else if (tick) begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

`ifdef DEBOUNCE_LONG_PRESS_EN
  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);

  logic [HW-1:0]     hold [NUM_CH];
  logic [NUM_CH-1:0] fired;

  // hold saturates at its last value; fired keeps the pulse to one per press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      long_press <= '0;
      fired      <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        hold[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        long_press[i] <= 1'b0;
        if (!data_out[i]) begin
          hold[i]  <= '0;
          fired[i] <= 1'b0;
        end else if (tick) begin
          if (hold[i] == HOLD_LAST) begin
            if (!fired[i]) begin
              long_press[i] <= 1'b1;
              fired[i]      <= 1'b1;
            end
          end else begin
            hold[i] <= hold[i] + 1'b1;
          end
        end
      end
    end
  end
`else
  assign long_press = '0;
`endif

endmodule

// File: tb/tb_debouncer_multi.sv
// Directed, table-driven bench for debouncer_multi (NUM_CH=4, STABLE_CYCLES=8, LONG_CYCLES=20).
// Long-press expectations follow DEBOUNCE_LONG_PRESS_EN; without it long_press must stay 0.
module tb_debouncer_multi;

`ifdef DEBOUNCE_LONG_PRESS_EN
  localparam logic [3:0] LP_CH0 = 4'h1;
`else
  localparam logic [3:0] LP_CH0 = 4'h0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick;
  logic [3:0] data_in;
  logic [3:0] data_out;
  logic [3:0] rise;
  logic [3:0] fall;
  logic [3:0] long_press;

  typedef struct {
    logic [3:0] din;
    logic       tck;
    int         n;
    logic [3:0] out;
    logic [3:0] rs;
    logic [3:0] fl;
    logic [3:0] lp;
  } vec_t;

  vec_t       vq[$];
  int         checks   = 0;
  int         failures = 0;
  logic [3:0] exp_prev;
  int         a_end;
  int         b_end;

  debouncer_multi #(
    .NUM_CH(4),
    .STABLE_CYCLES(8),
    .RST_VAL(1'b0),
    .LONG_CYCLES(20)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .tick(tick),
    .data_in(data_in),
    .data_out(data_out),
    .rise(rise),
    .fall(fall),
    .long_press(long_press)
  );

  always #5 clk = ~clk;

  task automatic add(input logic [3:0] din, input logic tck, input int n,
                     input logic [3:0] out, input logic [3:0] rs,
                     input logic [3:0] fl, input logic [3:0] lp);
    vec_t v;
    v.din = din;
    v.tck = tck;
    v.n   = n;
    v.out = out;
    v.rs  = rs;
    v.fl  = fl;
    v.lp  = lp;
    vq.push_back(v);
  endtask

  task automatic applyStimulus(input logic [3:0] din, input logic tck);
    data_in = din;
    tick    = tck;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] e_out,
                             input logic [3:0] e_rise, input logic [3:0] e_fall,
                             input logic [3:0] e_lp);
    checks++;
    if ({data_out, rise, fall, long_press} !== {e_out, e_rise, e_fall, e_lp}) begin
      failures++;
      $display("[TB] FAIL %s: got out=%h rise=%h fall=%h lp=%h, expected out=%h rise=%h fall=%h lp=%h",
               name, data_out, rise, fall, long_press, e_out, e_rise, e_fall, e_lp);
    end
  endtask

  // Every edge before the last of a record must show the previous level and no pulses.
  task automatic run_vectors(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      applyStimulus(vq[i].din, vq[i].tck);
      for (int k = 1; k <= vq[i].n; k++) begin
        step();
        if (k < vq[i].n)
          checkOutput($sformatf("vec%0d_edge%0d", i, k), exp_prev, 4'h0, 4'h0, 4'h0);
        else
          checkOutput($sformatf("vec%0d_final", i), vq[i].out, vq[i].rs, vq[i].fl, vq[i].lp);
      end
      exp_prev = vq[i].out;
    end
  endtask

  initial begin
    // Qualify all channels, glitch widths 7 and 8, bounce on ch1.
    add(4'hF, 1'b1, 10, 4'hF, 4'hF, 4'h0, 4'h0);
    add(4'hF, 1'b1,  1, 4'hF, 4'h0, 4'h0, 4'h0);
    add(4'h0, 1'b1, 10, 4'h0, 4'h0, 4'hF, 4'h0);
    add(4'h0, 1'b1,  2, 4'h0, 4'h0, 4'h0, 4'h0);
    add(4'h1, 1'b1,  7, 4'h0, 4'h0, 4'h0, 4'h0);
    add(4'h0, 1'b1,  6, 4'h0, 4'h0, 4'h0, 4'h0);
    add(4'h1, 1'b1,  8, 4'h0, 4'h0, 4'h0, 4'h0);
    add(4'h0, 1'b1,  2, 4'h1, 4'h1, 4'h0, 4'h0);
    add(4'h0, 1'b1,  8, 4'h0, 4'h0, 4'h1, 4'h0);
    add(4'h0, 1'b1,  2, 4'h0, 4'h0, 4'h0, 4'h0);
    for (int b = 0; b < 5; b++) begin
      add(4'h2, 1'b1, 3, 4'h0, 4'h0, 4'h0, 4'h0);
      add(4'h0, 1'b1, 3, 4'h0, 4'h0, 4'h0, 4'h0);
    end
    add(4'h2, 1'b1, 10, 4'h2, 4'h2, 4'h0, 4'h0);
    add(4'h0, 1'b1, 10, 4'h0, 4'h0, 4'h2, 4'h0);
    add(4'h0, 1'b1,  2, 4'h0, 4'h0, 4'h0, 4'h0);
    a_end = vq.size();
    // Count holds without tick, a match clears it without tick, then full requalification.
    add(4'h0, 1'b0,  6, 4'h4, 4'h0, 4'h0, 4'h0);
    add(4'h0, 1'b1,  5, 4'h4, 4'h0, 4'h0, 4'h0);
    add(4'h4, 1'b0,  4, 4'h4, 4'h0, 4'h0, 4'h0);
    add(4'h0, 1'b1, 10, 4'h0, 4'h0, 4'h4, 4'h0);
    add(4'h4, 1'b1, 10, 4'h4, 4'h4, 4'h0, 4'h0);
    add(4'hC, 1'b1,  7, 4'h4, 4'h0, 4'h0, 4'h0);
    b_end = vq.size();
    // After the mid-count reset: requalify, then long-press sequences on ch0.
    add(4'hC, 1'b1, 10, 4'hC, 4'hC, 4'h0, 4'h0);
    add(4'h0, 1'b1, 10, 4'h0, 4'h0, 4'hC, 4'h0);
    add(4'h1, 1'b1, 10, 4'h1, 4'h1, 4'h0, 4'h0);
    add(4'h1, 1'b1, 20, 4'h1, 4'h0, 4'h0, LP_CH0);
    add(4'h1, 1'b1, 30, 4'h1, 4'h0, 4'h0, 4'h0);
    add(4'h0, 1'b1, 10, 4'h0, 4'h0, 4'h1, 4'h0);
    add(4'h1, 1'b1, 10, 4'h1, 4'h1, 4'h0, 4'h0);
    add(4'h1, 1'b1, 20, 4'h1, 4'h0, 4'h0, LP_CH0);
    add(4'h0, 1'b1, 10, 4'h0, 4'h0, 4'h1, 4'h0);

    rst_n = 1'b0;
    applyStimulus(4'hF, 1'b1);
    exp_prev = 4'h0;
    repeat (3) step();
    checkOutput("reset_state", 4'h0, 4'h0, 4'h0, 4'h0);
    rst_n = 1'b1;

    $display("[TB] qualify, glitch and bounce vectors");
    run_vectors(0, a_end);

    $display("[TB] tick every 4th cycle on ch2");
    for (int e = 1; e <= 40; e++) begin
      applyStimulus(4'h4, (e % 4) == 0);
      step();
      checkOutput($sformatf("tick_gate_edge%0d", e), (e >= 32) ? 4'h4 : 4'h0,
                  (e == 32) ? 4'h4 : 4'h0, 4'h0, 4'h0);
    end
    tick     = 1'b1;
    exp_prev = 4'h4;

    $display("[TB] count hold/clear and mid-count setup");
    run_vectors(a_end, b_end);

    $display("[TB] asynchronous reset mid-count");
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_immediate", 4'h0, 4'h0, 4'h0, 4'h0);
    step();
    checkOutput("async_reset_held1", 4'h0, 4'h0, 4'h0, 4'h0);
    step();
    checkOutput("async_reset_held2", 4'h0, 4'h0, 4'h0, 4'h0);
    rst_n    = 1'b1;
    exp_prev = 4'h0;

    $display("[TB] requalify and long press");
    run_vectors(b_end, vq.size());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
